// File: rtl/seq_multiplier.sv
// seq_multiplier
// ---------------------------------------------------------------------------
// Shift-add sequential multiplier. It computes an unsigned WIDTH x WIDTH ->
// 2*WIDTH product and adds one partial product per clock. Any WIDTH >= 2 is
// supported.
//
// Handshake: start is sampled on a rising clk edge whenever busy=0, which is
// in IDLE or in the single DONE cycle. The accepting edge captures a and b,
// and busy stays high until the edge that produces the result. done pulses
// for exactly one cycle. During that cycle p holds the new product, and a
// start seen in the DONE cycle is accepted at once, so results can be issued
// back-to-back with no gap.
//
// Optional feature (compile-time macro MULT_EARLY_DONE_EN):
//   When defined, BUSY also finishes as soon as the remaining multiplier bits
//   are all zero. Latency is then max(1, msb_index(b)+1) cycles. When
//   undefined, latency is always WIDTH cycles.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   operation request (accepted when busy=0)
//   a         in   [WIDTH-1:0] multiplicand, captured on accepted start
//   b         in   [WIDTH-1:0] multiplier, captured on accepted start
//   busy      out  high while state is BUSY
//   done      out  one-cycle pulse while state is DONE, p valid
//   p         out  [2*WIDTH-1:0] product, held until the next completion
//   state_dbg out  [1:0] current FSM state (0 IDLE, 1 BUSY, 2 DONE)
// ---------------------------------------------------------------------------
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p,
  output logic [1:0]           state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic [2*WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0]   mplier_nxt;
  logic               last_step;
  logic               load_en;

  // Datapath helpers. acc_sum already includes this step's partial product,
  // so the exit edge can publish it straight into p.
  always_comb begin
    acc_sum    = acc + (mplier[0] ? mcand : '0);
    mplier_nxt = mplier >> 1;
`ifdef MULT_EARLY_DONE_EN
    // Once no multiplier bits remain, further steps would only add zero.
    last_step  = (cnt == CNT_LAST) || (mplier_nxt == '0);
`else
    last_step  = (cnt == CNT_LAST);
`endif
    load_en    = start && ((state == S_IDLE) || (state == S_DONE));
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next-state logic. start is ignored while BUSY.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = start     ? S_BUSY : S_IDLE;
      S_BUSY:  state_nxt = last_step ? S_DONE : S_BUSY;
      S_DONE:  state_nxt = start     ? S_BUSY : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs. These decode directly from the state register, so an
  // asynchronous reset clears them immediately.
  always_comb begin
    busy      = (state == S_BUSY);
    done      = (state == S_DONE);
    state_dbg = state;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      p      <= '0;
    end else if (load_en) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == S_BUSY) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier_nxt;
      cnt    <= cnt + 1'b1;
      if (last_step) begin
        p <= acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier
// ---------------------------------------------------------------------------
// Bench for seq_multiplier. It runs two instances, WIDTH=4 and WIDTH=8, on a
// shared clock and reset. The reference model is plain arithmetic: the
// product is a*b, and the latency is WIDTH cycles, or max(1, msb(b)+1)
// cycles when MULT_EARLY_DONE_EN is defined.
//
// Handshake under check: start is accepted on a rising edge while busy=0;
// done is a one-cycle pulse carrying a new p.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4;
  logic [7:0]  p4;
  logic [1:0]  st4;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] p8;
  logic [1:0]  st8;

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .p(p4), .state_dbg(st4)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .p(p8), .state_dbg(st8)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  int dn4 = 0, dn8 = 0;
  int exp_dn4 = 0, exp_dn8 = 0;
  logic [7:0]  exp_q4[$];
  logic [15:0] exp_q8[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int ref_lat(input int w, input int bv);
`ifdef MULT_EARLY_DONE_EN
    int h;
    h = 0;
    for (int i = 0; i < w; i++) if ((bv >> i) & 1) h = i + 1;
    return (h < 1) ? 1 : h;
`else
    return w;
`endif
  endfunction

  // ---------------- scoreboard: product on every done ----------------
  always @(negedge clk) begin
    if (rst_n && done4) begin
      dn4++;
      if (exp_q4.size() == 0) check("done4_unexpected", 32'd1, 32'd0);
      else check("product4", {24'd0, p4}, {24'd0, exp_q4.pop_front()});
    end
    if (rst_n && done8) begin
      dn8++;
      if (exp_q8.size() == 0) check("done8_unexpected", 32'd1, 32'd0);
      else check("product8", {16'd0, p8}, {16'd0, exp_q8.pop_front()});
    end
  end

  // ---------------- driver helpers ----------------
  function automatic logic busy_of(input int w);
    return (w == 4) ? busy4 : busy8;
  endfunction

  function automatic logic done_of(input int w);
    return (w == 4) ? done4 : done8;
  endfunction

  task automatic set_ops(input int w, input logic [7:0] av, input logic [7:0] bv, input logic st);
    if (w == 4) begin
      a4 = av[3:0]; b4 = bv[3:0]; start4 = st;
    end else begin
      a8 = av; b8 = bv; start8 = st;
    end
  endtask

  task automatic wait_idle(input int w);
    int i;
    for (i = 0; i < 50; i++) begin
      if (!busy_of(w)) break;
      @(posedge clk); #1;
    end
    if (i == 50) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // One operation: start pulse, noisy a/b/start while BUSY, latency check.
  task automatic run_op(input int w, input logic [7:0] av, input logic [7:0] bv);
    int lat;
    int el;
    int mask;
    bit seen;
    mask = (w == 4) ? 15 : 255;
    wait_idle(w);
    set_ops(w, av, bv, 1'b1);
    @(posedge clk); #1;
    if (w == 4) begin
      exp_q4.push_back(8'((av & mask) * (bv & mask)));
      exp_dn4++;
    end else begin
      exp_q8.push_back(16'((av & mask) * (bv & mask)));
      exp_dn8++;
    end
    check("busy_after_accept", {31'd0, busy_of(w)}, 32'd1);
    el = ref_lat(w, bv & mask);
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      set_ops(w, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      @(posedge clk); #1;
      lat++;
      if (done_of(w)) begin
        seen = 1'b1;
        break;
      end
    end
    set_ops(w, 8'($urandom), 8'($urandom), 1'b0);
    check("done_seen", {31'd0, seen}, 32'd1);
    check("latency", lat, el);
    check("busy_in_done", {31'd0, busy_of(w)}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    logic [7:0] qa[4];
    logic [7:0] qb[4];

    // reset state
    #12;
    check("rst_busy4", {31'd0, busy4}, 32'd0);
    check("rst_done4", {31'd0, done4}, 32'd0);
    check("rst_p4", {24'd0, p4}, 32'd0);
    check("rst_p8", {16'd0, p8}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed 9*6, then p holds through idle cycles
    run_op(4, 8'd9, 8'd6);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold_done4", {31'd0, done4}, 32'd0);
      check("hold_busy4", {31'd0, busy4}, 32'd0);
      check("hold_p4", {24'd0, p4}, 32'd54);
    end

    // exhaustive WIDTH=4, issued as soon as busy=0
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        run_op(4, 8'(x), 8'(y));

    // directed WIDTH=8 corner operands
    run_op(8, 8'd200, 8'd3);
    run_op(8, 8'd255, 8'd0);
    run_op(8, 8'd255, 8'd255);
    run_op(8, 8'd0, 8'd255);
    run_op(8, 8'd1, 8'd128);

    // random WIDTH=8
    for (int k = 0; k < 150; k++)
      run_op(8, 8'($urandom), 8'($urandom_range(0, 255)));

    // back-to-back with start held high
    wait_idle(8);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      qa[k] = 8'($urandom);
      qb[k] = 8'($urandom_range(1, 255));
    end
    a8 = qa[0]; b8 = qb[0]; start8 = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      exp_q8.push_back(16'(qa[k] * qb[k]));
      exp_dn8++;
      if (k < 3) begin
        a8 = qa[k+1]; b8 = qb[k+1];
      end else begin
        start8 = 1'b0;
      end
      lat = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        lat++;
        if (done8) break;
      end
      check("b2b_latency", lat, ref_lat(8, qb[k]));
      if (k < 3) begin
        @(posedge clk); #1;
        check("b2b_no_gap", {31'd0, busy8}, 32'd1);
      end
    end

    // asynchronous reset mid-operation (p4 currently non-zero)
    wait_idle(4);
    @(posedge clk); #1;
    a4 = 4'd7; b4 = 4'd7; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy4", {31'd0, busy4}, 32'd0);
    check("arst_done4", {31'd0, done4}, 32'd0);
    check("arst_p4", {24'd0, p4}, 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("no_done_after_reset", {31'd0, done4}, 32'd0);
    end
    run_op(4, 8'd3, 8'd5);
    @(posedge clk); #1;
    check("post_reset_p4", {24'd0, p4}, 32'd15);

    // final accounting
    @(posedge clk); #1;
    check("done_count4", dn4, exp_dn4);
    check("done_count8", dn8, exp_dn8);
    check("queue4_empty", exp_q4.size(), 0);
    check("queue8_empty", exp_q8.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
